// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among NUM_REQ clients. Round-robin pick among
//   requesting clients, gated by CTS, Tx_Busy and BIST_Busy. It sequences the
//   Transmit_Start/Tx_Busy handshake, drops a frame whose transmitter never
//   starts, and reports completion per client.
// Ports
//   Clk, Rst_n     baud clock (rising edge) and async active-low reset
//   Req, Req_Data  level request per client and packed client data
//   Grant, Done    one-hot pulses: data captured / frame transmitted
//   Start_Err      pulse: transmitter never acknowledged the start strobe
//   CTS, BIST_Busy gate new frames only (IDLE -> START)
//   Tx_Busy        UART busy; Tx_Data/Transmit_Start drive the UART core
//   Arb_Busy       high whenever a frame is in flight
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_BITS     = 8,
    parameter int START_TIMEOUT = 16
) (
    input  logic                           Clk,
    input  logic                           Rst_n,
    input  logic [NUM_REQ-1:0]             Req,
    input  logic [NUM_REQ*DATA_BITS-1:0]   Req_Data,
    output logic [NUM_REQ-1:0]             Grant,
    output logic [NUM_REQ-1:0]             Done,
    output logic                           Start_Err,
    input  logic                           CTS,
    input  logic                           BIST_Busy,
    input  logic                           Tx_Busy,
    output logic [DATA_BITS-1:0]           Tx_Data,
    output logic                           Transmit_Start,
    output logic                           Arb_Busy
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

    state_t               state, state_n;
    logic [OW-1:0]        rr_ptr, rr_ptr_n, owner, owner_n, owner_inc, winner;
    logic [CW-1:0]        cnt, cnt_n;
    logic [NUM_REQ-1:0]   grant_n, done_n;
    logic                 start_err_n, ts_n;
    logic [DATA_BITS-1:0] tx_data_n;
    logic                 eligible;

    assign eligible  = (|Req) && CTS && !Tx_Busy && !BIST_Busy;
    assign owner_inc = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign Arb_Busy  = (state != IDLE);

    // Search downward so the last hit kept is the nearest requester at or
    // after rr_ptr (wrapping).
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (Req[idx]) winner = OW'(idx);
        end
    end

    always_comb begin
        state_n     = state;
        rr_ptr_n    = rr_ptr;
        owner_n     = owner;
        cnt_n       = cnt;
        tx_data_n   = Tx_Data;
        ts_n        = Transmit_Start;
        grant_n     = '0;
        done_n      = '0;
        start_err_n = 1'b0;
        case (state)
            IDLE: begin
                if (eligible) begin
                    owner_n          = winner;
                    tx_data_n        = Req_Data[winner*DATA_BITS +: DATA_BITS];
                    grant_n[winner]  = 1'b1;
                    ts_n             = 1'b1;
                    cnt_n            = '0;
                    state_n          = START;
                end
            end
            START: begin
                if (Tx_Busy) begin
                    ts_n    = 1'b0;
                    state_n = WAIT_DONE;
                end else if (cnt == CW'(START_TIMEOUT - 1)) begin
                    // Transmitter never acknowledged: drop the frame, move on.
                    ts_n        = 1'b0;
                    start_err_n = 1'b1;
                    rr_ptr_n    = owner_inc;
                    state_n     = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!Tx_Busy) begin
                    done_n[owner] = 1'b1;
                    rr_ptr_n      = owner_inc;
                    state_n       = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            owner          <= '0;
            cnt            <= '0;
            Tx_Data        <= '0;
            Transmit_Start <= 1'b0;
            Grant          <= '0;
            Done           <= '0;
            Start_Err      <= 1'b0;
        end else begin
            state          <= state_n;
            rr_ptr         <= rr_ptr_n;
            owner          <= owner_n;
            cnt            <= cnt_n;
            Tx_Data        <= tx_data_n;
            Transmit_Start <= ts_n;
            Grant          <= grant_n;
            Done           <= done_n;
            Start_Err      <= start_err_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DB = 8;
    localparam logic [7:0] HANG = 8'hDE;   // UART model never starts on this byte

    logic           Clk = 0, Rst_n;
    logic [NR-1:0]  Req, Grant, Done;
    logic [NR*DB-1:0] Req_Data;
    logic           Start_Err, CTS, BIST_Busy, Tx_Busy, Transmit_Start, Arb_Busy;
    logic [DB-1:0]  Tx_Data;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB), .START_TIMEOUT(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Req_Data(Req_Data),
        .Grant(Grant), .Done(Done), .Start_Err(Start_Err),
        .CTS(CTS), .BIST_Busy(BIST_Busy), .Tx_Busy(Tx_Busy),
        .Tx_Data(Tx_Data), .Transmit_Start(Transmit_Start), .Arb_Busy(Arb_Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int        kind;   // 0 grant, 1 done, 2 start error
        logic [3:0] vec;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0, errors = 0;
    int cyc = 0, grant_cnt = 0, ts_rise = 0, fall_cyc = 0, busy_len = 12;
    logic ts_prev = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // UART core model: acknowledges Transmit_Start by going busy for busy_len cycles
    initial begin
        Tx_Busy = 0;
        forever begin
            @(negedge Clk);
            if (Rst_n && Transmit_Start && !Tx_Busy && Tx_Data != HANG) begin
                Tx_Busy = 1;
                for (int i = 0; i < busy_len; i++) begin
                    @(negedge Clk);
                    if (!Rst_n) break;
                end
                Tx_Busy  = 0;
                fall_cyc = cyc;
            end
        end
    end

    function automatic void push(input int kind, input logic [3:0] vec, input logic [7:0] data);
        exp_t e;
        e.kind = kind; e.vec = vec; e.data = data;
        exp_q.push_back(e);
    endfunction

    task automatic sb_check(input int kind, input logic [3:0] vec, input logic [7:0] data);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got kind %0d vec %b data %h, want nothing", kind, vec, data);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.vec != vec || (kind == 0 && e.data != data)) begin
            errors++;
            $display("FAIL sb_event: got kind %0d vec %b data %h, want kind %0d vec %b data %h",
                     kind, vec, data, e.kind, e.vec, e.data);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (Transmit_Start && !ts_prev) ts_rise = cyc;
            if (Grant != 0 && Done != 0) begin
                checks++; errors++;
                $display("FAIL grant_done_overlap: Grant %b Done %b", Grant, Done);
            end
            if (Grant != 0) begin
                sb_check(0, Grant, Tx_Data);
                chk("start_with_grant", 32'(Transmit_Start), 32'd1);
                grant_cnt++;
            end
            if (Done != 0) begin
                sb_check(1, Done, 8'h00);
                chk("done_latency", 32'(cyc - fall_cyc), 32'd1);
            end
            if (Start_Err) begin
                sb_check(2, 4'b0000, 8'h00);
                chk("timeout_latency", 32'(cyc - ts_rise), 32'd16);
            end
        end
        ts_prev = Transmit_Start;
    end

    task automatic wait_grants(input int n);
        int k = 0;
        while (grant_cnt < n && k < 500) begin
            @(negedge Clk); #1; k++;
        end
        chk("wait_grant", 32'(grant_cnt >= n), 32'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_q.size() != 0 || Arb_Busy) && k < 2000) begin
            @(negedge Clk); #1; k++;
        end
        chk("wait_idle_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic set_data(input int c, input logic [7:0] v);
        Req_Data[c*DB +: DB] = v;
    endtask

    initial begin
        int g0;
        Rst_n = 0; Req = 4'hF; CTS = 1; BIST_Busy = 0; Req_Data = '0;
        for (int c = 0; c < NR; c++) set_data(c, 8'h10 + 8'(c));
        #3;
        // Reset state with all clients requesting
        chk("rst_grant", 32'(Grant), 32'h0);
        chk("rst_done", 32'(Done), 32'h0);
        chk("rst_err", 32'(Start_Err), 32'h0);
        chk("rst_ts", 32'(Transmit_Start), 32'h0);
        chk("rst_txdata", 32'(Tx_Data), 32'h0);

        // Fairness: 0,1,2,3 then 0 again
        busy_len = 4;
        for (int i = 0; i < 5; i++) begin
            push(0, 4'(1 << (i % 4)), 8'h10 + 8'(i % 4));
            push(1, 4'(1 << (i % 4)), 8'h00);
        end
        @(negedge Clk); #1; Rst_n = 1;
        wait_grants(5);
        Req = 4'h0;
        wait_idle();

        // Single client 2
        busy_len = 12;
        set_data(2, 8'hA5);
        push(0, 4'b0100, 8'hA5); push(1, 4'b0100, 8'h00);
        Req = 4'b0100;
        wait_grants(6);
        Req = 4'b0000;
        wait_idle();

        // Flow control gating
        busy_len = 3;
        set_data(0, 8'h5A);
        CTS = 0; Req = 4'b0001;
        g0 = grant_cnt;
        repeat (50) @(negedge Clk);
        #1 chk("cts_hold", 32'(grant_cnt), 32'(g0));
        CTS = 1; BIST_Busy = 1;
        repeat (50) @(negedge Clk);
        #1 chk("bist_hold", 32'(grant_cnt), 32'(g0));
        push(0, 4'b0001, 8'h5A); push(1, 4'b0001, 8'h00);
        BIST_Busy = 0;
        @(negedge Clk); #1;
        chk("release_latency", 32'(grant_cnt), 32'(g0 + 1));
        Req = 4'b0000;
        wait_idle();

        // Timeout on client 1, then client 2 served
        set_data(1, HANG); set_data(2, 8'h77);
        push(0, 4'b0010, HANG); push(2, 4'b0000, 8'h00);
        push(0, 4'b0100, 8'h77); push(1, 4'b0100, 8'h00);
        Req = 4'b0110;
        wait_grants(g0 + 2);
        Req[1] = 0;
        wait_grants(g0 + 3);
        Req[2] = 0;
        wait_idle();

        // Abort in WAIT_DONE, then pointer restarts at 0
        busy_len = 30;
        set_data(2, 8'h3C);
        push(0, 4'b0100, 8'h3C);
        Req = 4'b0100;
        wait_grants(g0 + 4);
        Req = 4'b0000;
        repeat (5) @(negedge Clk);
        chk("abort_in_frame", 32'(Arb_Busy && Tx_Busy), 32'd1);
        #2 Rst_n = 0;
        #1;
        chk("abort_ts", 32'(Transmit_Start), 32'd0);
        chk("abort_busy", 32'(Arb_Busy), 32'd0);
        chk("abort_txdata", 32'(Tx_Data), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_pending", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge Clk);
        busy_len = 5;
        set_data(1, 8'h81); set_data(3, 8'h83);
        push(0, 4'b0010, 8'h81); push(1, 4'b0010, 8'h00);
        push(0, 4'b1000, 8'h83); push(1, 4'b1000, 8'h00);
        Req = 4'b1010;
        #1 Rst_n = 1;
        wait_grants(g0 + 5);
        Req[1] = 0;
        wait_grants(g0 + 6);
        Req[3] = 0;
        wait_idle();

        repeat (5) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, %0d checks %0d errors", checks, errors);
        $fatal(1);
    end
endmodule
